// File: rtl/stopwatch_pkg.sv
// Shared constants and press-FSM encoding for the stopwatch
// button path.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      PRESSED = 2'd1,
      HELD    = 2'd2
   } press_state_t;

   localparam int DEF_DEBOUNCE_CYCLES = 500000;
   localparam int DEF_HOLD_CYCLES     = 50000000;

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a restartable
// stability counter that yields a clean button level.
module debounce_filter #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_in,
   output logic btn_level
);

   localparam int DBW =
      (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CYCLES - 1);

   logic           sync_q1;
   logic           btn_sync;
   logic [DBW-1:0] db_cnt;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_q1  <= 1'b0;
         btn_sync <= 1'b0;
      end else begin
         sync_q1  <= btn_in;
         btn_sync <= sync_q1;
      end
   end

   // any sample equal to the current level restarts the count
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         db_cnt    <= '0;
         btn_level <= 1'b0;
      end else if (btn_sync != btn_level) begin
         if (db_cnt == DB_LAST) begin
            db_cnt    <= '0;
            btn_level <= ~btn_level;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end else begin
         db_cnt <= '0;
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Turns one bouncy push-button into a debounced level plus
// short-press and long-hold strobes.
module button_conditioner
   import stopwatch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES
) (
   input  logic clk,
   input  logic reset_n,
   input  logic btn_in,
   output logic btn_level,
   output logic short_pulse,
   output logic long_pulse
);

   localparam int HW = $clog2(HOLD_CYCLES + 1);
   // FSM enters PRESSED one edge after the level rises,
   // so the count that marks the hold is two short of it
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 2);

   press_state_t  state_q;
   press_state_t  state_d;
   logic [HW-1:0] hold_cnt;
   logic [HW-1:0] hold_cnt_d;
   logic          long_d;

   debounce_filter #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk       (clk),
      .reset_n   (reset_n),
      .btn_in    (btn_in),
      .btn_level (btn_level)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         hold_cnt   <= '0;
         long_pulse <= 1'b0;
      end else begin
         state_q    <= state_d;
         hold_cnt   <= hold_cnt_d;
         long_pulse <= long_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      hold_cnt_d = hold_cnt;
      long_d     = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (btn_level) begin
               state_d    = PRESSED;
               hold_cnt_d = '0;
            end
         end
         PRESSED: begin
            if (!btn_level) begin
               state_d = IDLE;
            end else if (hold_cnt == HOLD_LAST) begin
               state_d = HELD;
               long_d  = 1'b1;
            end else begin
               hold_cnt_d = hold_cnt + 1'b1;
            end
         end
         HELD: begin
            if (!btn_level) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // decoded from flops only: level has just fallen while pressed
   assign short_pulse = (state_q == PRESSED) && !btn_level;

endmodule
